// File: rtl/jtag_tap_emulator.sv
// Soft IEEE 1149.1 TAP controller exposing the ER1/ER2 user-register interface.
// Optional macro JTAG_IDCODE_EN adds the IDCODE instruction and 32-bit IDCODE register.
module jtag_tap_emulator #(
    parameter int                IR_LEN     = 8,
    parameter logic [31:0]       IDCODE_VAL = 32'h41111043,
    parameter logic [IR_LEN-1:0] IDCODE_OP  = 8'hE0,
    parameter logic [IR_LEN-1:0] ER1_OP     = 8'h32,
    parameter logic [IR_LEN-1:0] ER2_OP     = 8'h38,
    parameter logic [IR_LEN-1:0] BYPASS_OP  = 8'hFF
) (
    input  logic JTCK,
    input  logic JRST,
    input  logic TMS,
    input  logic TDI,
    output logic TDO,
    output logic TDO_OE,
    output logic JTDI,
    output logic JSHIFT,
    output logic JUPDATE,
    output logic JRSTN,
    output logic JCE1,
    output logic JCE2,
    output logic JRTI1,
    output logic JRTI2,
    input  logic JTD1,
    input  logic JTD2
);

    typedef enum logic [3:0] {
        ST_TLR,
        ST_RTI,
        ST_SEL_DR,
        ST_CAP_DR,
        ST_SH_DR,
        ST_EX1_DR,
        ST_PAU_DR,
        ST_EX2_DR,
        ST_UPD_DR,
        ST_SEL_IR,
        ST_CAP_IR,
        ST_SH_IR,
        ST_EX1_IR,
        ST_PAU_IR,
        ST_EX2_IR,
        ST_UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_ER1,
        DR_ER2
    } dr_sel_t;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_LEN-1:0] IR_RESET = IDCODE_OP;
`else
    localparam logic [IR_LEN-1:0] IR_RESET = BYPASS_OP;
    logic unused_idcode_cfg;
    assign unused_idcode_cfg = ^{IDCODE_VAL, IDCODE_OP};
`endif

    // Capture-IR pattern: LSB shifts out first as 1, then zeros.
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

    tap_state_t        state_reg;
    tap_state_t        state_next;
    logic [IR_LEN-1:0] ir_reg;
    logic [IR_LEN-1:0] ir_shift_reg;
    logic [IR_LEN-1:0] ir_shift_in;
    logic              bypass_reg;
    logic              tdo_reg;
    logic              tdo_oe_reg;
    logic              tdo_next;
    dr_sel_t           dr_sel;
`ifdef JTAG_IDCODE_EN
    logic [31:0]       idcode_reg;
`endif

    // TAP state transitions on TMS.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_TLR:    state_next = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_next = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_next = TMS ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_next = TMS ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_next = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_next = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_next = TMS ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_next = TMS ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_next = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_next = TMS ? ST_SEL_DR : ST_RTI;
            default:   state_next = ST_TLR;
        endcase
    end

    // Instruction decode; anything not recognised falls back to bypass.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_reg == ER1_OP) begin
            dr_sel = DR_ER1;
        end else if (ir_reg == ER2_OP) begin
            dr_sel = DR_ER2;
        end
`ifdef JTAG_IDCODE_EN
        else if (ir_reg == IDCODE_OP) begin
            dr_sel = DR_IDCODE;
        end
`endif
    end

    // IR shift path: each bit takes its upper neighbour, TDI enters the MSB.
    generate
        for (genvar gi = 0; gi < IR_LEN; gi++) begin : g_ir_bit
            if (gi == IR_LEN - 1) begin : g_msb
                assign ir_shift_in[gi] = TDI;
            end else begin : g_lower
                assign ir_shift_in[gi] = ir_shift_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            state_reg    <= ST_TLR;
            ir_reg       <= IR_RESET;
            ir_shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next == ST_TLR) begin
                ir_reg <= IR_RESET;
            end else if (state_reg == ST_UPD_IR) begin
                ir_reg <= ir_shift_reg;
            end
            if (state_reg == ST_CAP_IR) begin
                ir_shift_reg <= IR_CAPTURE;
            end else if (state_reg == ST_SH_IR) begin
                ir_shift_reg <= ir_shift_in;
            end
        end
    end

    // Internal data registers; ER1/ER2 data lives in the user cores.
    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            bypass_reg <= 1'b0;
        end else if (dr_sel == DR_BYPASS) begin
            if (state_reg == ST_CAP_DR) begin
                bypass_reg <= 1'b0;
            end else if (state_reg == ST_SH_DR) begin
                bypass_reg <= TDI;
            end
        end
    end

`ifdef JTAG_IDCODE_EN
    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            idcode_reg <= '0;
        end else if (dr_sel == DR_IDCODE) begin
            if (state_reg == ST_CAP_DR) begin
                idcode_reg <= IDCODE_VAL;
            end else if (state_reg == ST_SH_DR) begin
                idcode_reg <= {TDI, idcode_reg[31:1]};
            end
        end
    end
`endif

    always_comb begin
        tdo_next = 1'b0;
        if (state_reg == ST_SH_IR) begin
            tdo_next = ir_shift_reg[0];
        end else if (state_reg == ST_SH_DR) begin
            case (dr_sel)
                DR_ER1:    tdo_next = JTD1;
                DR_ER2:    tdo_next = JTD2;
`ifdef JTAG_IDCODE_EN
                DR_IDCODE: tdo_next = idcode_reg[0];
`endif
                default:   tdo_next = bypass_reg;
            endcase
        end
    end

    // TDO launches on the falling edge so the far end can sample on the next rise.
    always_ff @(negedge JTCK or posedge JRST) begin
        if (JRST) begin
            tdo_reg    <= 1'b0;
            tdo_oe_reg <= 1'b0;
        end else begin
            tdo_reg    <= tdo_next;
            tdo_oe_reg <= (state_reg == ST_SH_IR) || (state_reg == ST_SH_DR);
        end
    end

    assign TDO    = tdo_reg;
    assign TDO_OE = tdo_oe_reg;
    assign JTDI   = TDI;

    // User-side strobes are Moore outputs, forced idle while JRST is held.
    always_comb begin
        JRSTN   = ~JRST && (state_reg != ST_TLR);
        JSHIFT  = ~JRST && (state_reg == ST_SH_DR);
        JUPDATE = ~JRST && (state_reg == ST_UPD_DR);
        JCE1    = ~JRST && ((state_reg == ST_CAP_DR) || (state_reg == ST_SH_DR))
                  && (ir_reg == ER1_OP);
        JCE2    = ~JRST && ((state_reg == ST_CAP_DR) || (state_reg == ST_SH_DR))
                  && (ir_reg == ER2_OP);
        JRTI1   = ~JRST && (state_reg == ST_RTI) && (ir_reg == ER1_OP);
        JRTI2   = ~JRST && (state_reg == ST_RTI) && (ir_reg == ER2_OP);
    end

endmodule
